// File: rtl/fifo_v3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_v3_pkg
// Description : Shared constants for wrappers built on top of fifo_v3.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_v3_pkg;

    localparam int unsigned c_ftr_depth        = 1;
    localparam bit          c_ftr_fall_through = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fall_through_register.sv
`default_nettype none
// ============================================================================
// Module      : fall_through_register
// Description : Single-entry valid/ready register with same-cycle pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module fall_through_register
    import fifo_v3_pkg::*;
#(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  tri0  clr_i,
    input  tri0  testmode_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic w_full;
    logic w_empty;
    logic w_unused_usage;

    fifo_v3 #(
        .FALL_THROUGH (c_ftr_fall_through),
        .DEPTH        (c_ftr_depth),
        .dtype        (T)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (clr_i),
        .testmode_i (testmode_i),
        .full_o     (w_full),
        .empty_o    (w_empty),
        .usage_o    (w_unused_usage),
        .data_i     (data_i),
        .push_i     (valid_i),
        .data_o     (data_o),
        .pop_i      (ready_i)
    );

    assign ready_o = ~w_full;
    assign valid_o = ~w_empty;

endmodule
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// Module      : fifo_v3
// Description : Synchronous FIFO with any DEPTH >= 1 and optional fall-through.
//               Define FIFO_V3_ASSERTIONS_EN to compile simulation-only checks.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
    parameter bit           FALL_THROUGH = 1'b0,
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  DEPTH        = 8,
    parameter type          dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0]   c_depth_cnt = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] c_last_ptr  = ADDR_DEPTH'(DEPTH - 1);

    dtype                  r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [ADDR_DEPTH:0]   r_count;

    logic w_is_empty;
    logic w_ft_active;
    logic w_bypass;
    logic w_write;
    logic w_read;
    dtype w_head;
    logic w_unused;

    assign w_unused    = testmode_i;

    assign w_is_empty  = (r_count == '0);
    assign w_ft_active = FALL_THROUGH && w_is_empty && push_i;
    // A fall-through push that is popped in the same cycle never touches storage.
    assign w_bypass    = w_ft_active && pop_i;
    assign w_write     = push_i && !full_o && !w_bypass;
    assign w_read      = pop_i && !w_is_empty;

    assign full_o      = (r_count == c_depth_cnt);
    assign empty_o     = w_is_empty && !(FALL_THROUGH && push_i);
    assign usage_o     = r_count[ADDR_DEPTH-1:0];
    assign data_o      = w_ft_active ? data_i : w_head;

    always_comb begin
        w_head = r_mem[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (r_rd_ptr == ADDR_DEPTH'(i)) begin
                w_head = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_write && (r_wr_ptr == ADDR_DEPTH'(i))) begin
                    r_mem[i] <= data_i;
                end
            end
            if (w_write) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + ADDR_DEPTH'(1);
            end
            if (w_read) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + ADDR_DEPTH'(1);
            end
            if (w_write && !w_read) begin
                r_count <= r_count + (ADDR_DEPTH+1)'(1);
            end else if (w_read && !w_write) begin
                r_count <= r_count - (ADDR_DEPTH+1)'(1);
            end
        end
    end

`ifdef FIFO_V3_ASSERTIONS_EN
    if (DEPTH < 1) begin : g_depth_check
        $error("fifo_v3: DEPTH must be at least 1");
    end

    a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
        else $error("fifo_v3: push while full");

    a_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
        else $error("fifo_v3: pop while empty");
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_v3.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_v3
// Description : Randomized self-checking bench for fifo_v3 and its wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_v3;

    logic clk = 1'b0;
    logic rst_n;
    logic tmode = 1'b0;

    // index 0: DEPTH=4, 1: DEPTH=3, 2: DEPTH=4 fall-through
    logic [2:0]      push, pop, flush;
    logic [2:0][7:0] din;
    logic [2:0]      full, empty;
    logic [2:0][1:0] usage;
    logic [2:0][7:0] dout;

    logic       f_clr, f_valid_i, f_ready_o, f_valid_o, f_ready_i;
    logic [7:0] f_din, f_dout;

    int total = 0;
    int bad   = 0;

    logic [7:0] m [3][4];
    int         n [3];

    always #5 clk = ~clk;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .testmode_i(tmode),
        .full_o(full[0]), .empty_o(empty[0]), .usage_o(usage[0]),
        .data_i(din[0]), .push_i(push[0]), .data_o(dout[0]), .pop_i(pop[0]));

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .testmode_i(tmode),
        .full_o(full[1]), .empty_o(empty[1]), .usage_o(usage[1]),
        .data_i(din[1]), .push_i(push[1]), .data_o(dout[1]), .pop_i(pop[1]));

    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .testmode_i(tmode),
        .full_o(full[2]), .empty_o(empty[2]), .usage_o(usage[2]),
        .data_i(din[2]), .push_i(push[2]), .data_o(dout[2]), .pop_i(pop[2]));

    fall_through_register #(.T(logic [7:0])) u_ftr (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(f_clr), .testmode_i(tmode),
        .valid_i(f_valid_i), .ready_o(f_ready_o), .data_i(f_din),
        .valid_o(f_valid_o), .ready_i(f_ready_i), .data_o(f_dout));

    function automatic int dep(int i);
        return (i == 1) ? 3 : 4;
    endfunction

    function automatic bit ftf(int i);
        return (i == 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("full%0d", i),  32'(full[i]),  32'(n[i] == dep(i)));
            chk($sformatf("empty%0d", i), 32'(empty[i]), 32'((n[i] == 0) && !(ftf(i) && push[i])));
            chk($sformatf("usage%0d", i), 32'(usage[i]), 32'(n[i] % 4));
            if (n[i] > 0)
                chk($sformatf("data%0d", i), 32'(dout[i]), 32'(m[i][0]));
            else if (ftf(i) && push[i])
                chk($sformatf("ftdata%0d", i), 32'(dout[i]), 32'(din[i]));
        end
    endtask

    // Queue semantics: pop the head, then append if there was room beforehand.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            bit can_push, can_pop;
            if (!rst_n || flush[i]) begin
                n[i] = 0;
            end else if (!(ftf(i) && n[i] == 0 && push[i] && pop[i])) begin
                can_push = push[i] && (n[i] < dep(i));
                can_pop  = pop[i] && (n[i] > 0);
                if (can_pop) begin
                    for (int k = 0; k < 3; k++) m[i][k] = m[i][k+1];
                    n[i]--;
                end
                if (can_push) begin
                    m[i][n[i]] = din[i];
                    n[i]++;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        push = '0; pop = '0; flush = '0;
    endtask

    task automatic fill0(input logic [7:0] base, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            push = 3'b001; din[0] = base + 8'(k);
            step();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0; idle(); din = '0;
        f_clr = 1'b0; f_valid_i = 1'b0; f_ready_i = 1'b0; f_din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) n[i] = 0;

        // reset wins over push/pop
        push = 3'b111; pop = 3'b101; din = {8'h11, 8'h22, 8'h33};
        step();
        rst_n = 1'b1; idle();
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rst_data%0d", i), 32'(dout[i]), 32'h0);
        step();

        // fill DEPTH=4, then drain in order
        fill0(8'hA0, 4);
        #1 chk("full_after4", 32'(full[0]), 32'h1);
        step();
        for (int k = 0; k < 4; k++) begin
            pop = 3'b001;
            step();
        end
        idle();
        step();

        // push while full with pop: push dropped, pop executes
        fill0(8'hA0, 4);
        push = 3'b001; pop = 3'b001; din[0] = 8'hEE;
        step();
        idle();
        #1 chk("drop_usage", 32'(usage[0]), 32'h3);
        chk("drop_head", 32'(dout[0]), 32'hA1);
        step();
        flush = 3'b001;
        step();
        idle();

        // flush with simultaneous push
        fill0(8'hC0, 2);
        flush = 3'b001; push = 3'b001; din[0] = 8'h77;
        step();
        idle();
        #1 chk("flush_empty", 32'(empty[0]), 32'h1);
        chk("flush_usage", 32'(usage[0]), 32'h0);
        step();

        // fall-through push+pop on empty
        push = 3'b100; pop = 3'b100; din[2] = 8'h55;
        #1 chk("ft_data", 32'(dout[2]), 32'h55);
        chk("ft_empty", 32'(empty[2]), 32'h0);
        step();
        idle();
        #1 chk("ft_after_empty", 32'(empty[2]), 32'h1);
        chk("ft_after_usage", 32'(usage[2]), 32'h0);
        step();

        // random traffic with occasional flush and reset
        for (int c = 0; c < 600; c++) begin
            push  = 3'($urandom);
            pop   = 3'($urandom);
            flush = {($urandom_range(0, 40) == 0), ($urandom_range(0, 40) == 0),
                     ($urandom_range(0, 40) == 0)};
            din   = {8'($urandom), 8'($urandom), 8'($urandom)};
            rst_n = ($urandom_range(0, 200) != 0);
            step();
        end
        rst_n = 1'b1; idle();
        step();

        // fall_through_register: hold, then drain, then pass through
        f_valid_i = 1'b1; f_ready_i = 1'b0; f_din = 8'h3C;
        #1 chk("ftr_valid_now", 32'(f_valid_o), 32'h1);
        chk("ftr_data_now", 32'(f_dout), 32'h3C);
        chk("ftr_ready_now", 32'(f_ready_o), 32'h1);
        @(posedge clk); @(negedge clk);
        f_valid_i = 1'b0; f_ready_i = 1'b1; f_din = 8'h00;
        #1 chk("ftr_ready_held", 32'(f_ready_o), 32'h0);
        chk("ftr_valid_held", 32'(f_valid_o), 32'h1);
        chk("ftr_data_held", 32'(f_dout), 32'h3C);
        @(posedge clk); @(negedge clk);
        #1 chk("ftr_drained_valid", 32'(f_valid_o), 32'h0);
        chk("ftr_drained_ready", 32'(f_ready_o), 32'h1);
        f_valid_i = 1'b1; f_din = 8'hC3;
        #1 chk("ftr_pass_data", 32'(f_dout), 32'hC3);
        @(posedge clk); @(negedge clk);
        f_valid_i = 1'b0;
        #1 chk("ftr_pass_valid", 32'(f_valid_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_v3.md
FIFO_V3 -- requirements
Module: fifo_v3

Interface
REQ-001 Parameter FALL_THROUGH, default 1'b0: when 1, data written into an empty FIFO appears on data_o in the same cycle.
REQ-002 Parameter DATA_WIDTH, default 32: width of the entry when dtype is left at its default.
REQ-003 Parameter DEPTH, default 8: number of entries; legal range 1 and above; any value is allowed, not only powers of two.
REQ-004 Parameter dtype, default logic[DATA_WIDTH-1:0]: type of one stored entry.
REQ-005 Localparam ADDR_DEPTH = (DEPTH>1) ? $clog2(DEPTH) : 1.
REQ-006 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 Port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-008 Port flush_i, input, 1 bit: synchronous clear of all contents.
REQ-009 Port testmode_i, input, 1 bit: reserved test input with no functional effect.
REQ-010 Port full_o, output, 1 bit: FIFO holds DEPTH entries.
REQ-011 Port empty_o, output, 1 bit: no entry is available to pop.
REQ-012 Port usage_o, output, ADDR_DEPTH bits: current fill level; the full count reads as DEPTH truncated to ADDR_DEPTH bits.
REQ-013 Port data_i, input, dtype: write data.
REQ-014 Port push_i, input, 1 bit: write request.
REQ-015 Port data_o, output, dtype: head entry.
REQ-016 Port pop_i, input, 1 bit: read request.

Function
REQ-017 State: storage array mem[DEPTH], read pointer and write pointer (ADDR_DEPTH bits each), and an occupancy counter (ADDR_DEPTH+1 bits).
REQ-018 Write: push_i=1 and full_o=0 writes data_i to mem[wr_ptr], then wr_ptr increments and wraps from DEPTH-1 to 0.
REQ-019 Read: pop_i=1 and empty_o=0 increments rd_ptr, wrapping from DEPTH-1 to 0.
REQ-020 Occupancy: +1 on a write only, -1 on a read only, unchanged when both a write and a read happen in the same cycle.
REQ-021 Push while full (full_o=1): the push is ignored with no state change, even when pop_i=1; the pop still executes, so the count drops by 1.
REQ-022 Pop while empty (empty_o=1): ignored, no state change.
REQ-023 full_o = (count == DEPTH).
REQ-024 empty_o = (count == 0) AND NOT (FALL_THROUGH AND push_i).
REQ-025 data_o shows mem[rd_ptr] with zero latency (combinational read).
REQ-026 Fall-through: with FALL_THROUGH=1, count==0 and push_i=1, data_o = data_i in the same cycle.
REQ-027 Fall-through with pop_i=1 in that same cycle: the entry is consumed directly; pointers, count and storage stay unchanged.
REQ-028 Without FALL_THROUGH, first-write-to-data_o latency is 1 cycle.
REQ-029 flush_i=1 at a clock edge sets both pointers and the count to 0 and overrides push_i/pop_i in that cycle; storage contents are kept.

Reset
REQ-030 rst_ni=0 at a rising edge clears both pointers, the count and every storage entry to 0.
REQ-031 After reset: full_o=0, usage_o=0, data_o=0, and empty_o=1 unless a fall-through push is active.
REQ-032 Reset asserted mid-operation discards all contents and has priority over flush_i, push_i and pop_i.

Configuration
REQ-033 Macro FIFO_V3_ASSERTIONS_EN defined: the block includes simulation-only checks that error on DEPTH<1, on push_i while full_o, and on pop_i while empty_o.
REQ-034 Macro FIFO_V3_ASSERTIONS_EN undefined: no checks are compiled and the synthesised logic is identical.

Structure
REQ-035 fifo_v3 is self-contained and needs no package types.
REQ-036 Sub-module fall_through_register has parameter T and ports clk_i, rst_ni, clr_i, testmode_i, valid_i, ready_o, data_i, valid_o, ready_i, data_o.
REQ-037 fall_through_register instantiates fifo_v3 with DEPTH=1, FALL_THROUGH=1, dtype=T, connected as: push=valid_i, ready_o=~full_o, valid_o=~empty_o, pop=ready_i, flush=clr_i.
REQ-038 In fall_through_register, an unconnected clr_i or testmode_i is treated as 0.

Verification
REQ-039 DEPTH=4, FALL_THROUGH=0: push A,B,C,D on consecutive cycles -> full_o=1 and usage_o=0 (4 truncated to 2 bits); then pop 4 times -> data_o shows A,B,C,D in order, then empty_o=1.
REQ-040 DEPTH=4, full: push E and pop together -> E is dropped, count becomes 3, data_o=B.
REQ-041 DEPTH=3 (not a power of two): push and pop 7 entries with random gaps -> pointers wrap 2 to 0 and the output order matches the input order.
REQ-042 FALL_THROUGH=1, empty: push 0x55 with pop=1 -> data_o=0x55 and empty_o=0 in the same cycle; the next cycle has empty_o=1 and usage_o=0.
REQ-043 DEPTH=4 holding 2 entries: flush_i=1 together with push_i=1 -> next cycle has empty_o=1 and usage_o=0.
REQ-044 fall_through_register: valid_i=1 while ready_i=0 -> valid_o=1 the same cycle and ready_o=0 on the next cycle; ready_i=1 -> the entry drains.
